// File: rtl/ps2_pkg.sv
// PS/2 host transmit shared definitions.
// State encoding, frame length and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_REL
  } ps2_state_e;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // {stop, odd parity, data}, sent LSB first
  function automatic logic [FRAME_BITS-1:0] ps2_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop sync, FILTER_LEN debounce, fall pulse.
// Ports: clk_i/rst_i, line_i raw line, filt_o filtered level, fall_o 1->0 pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;
  logic          fall_q;
  logic          diff;

  assign diff   = sync_q[1] ^ filt_q;
  assign filt_o = filt_q;
  assign fall_o = fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (!diff) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        // FILTER_LEN-th consecutive differing sample
        filt_q <= sync_q[1];
        fall_q <= ~sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ack check and watchdog.
// Ports: tx_* request/status, ps2_*_in raw lines, ps2_*_drive_low open-drain pulls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e            state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [3:0]            bit_q;
  logic [IW-1:0]         inh_q;
  logic [WW-1:0]         wd_q;
  logic                  clk_dl_q;
  logic                  data_dl_q;
  logic                  done_q;
  logic                  err_q;

  logic clk_f;
  logic clk_fall;
  logic data_f;
  logic data_fall_unused;
  logic in_xfer;
  logic wd_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (ps2_clk_in),
    .filt_o (clk_f),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (ps2_data_in),
    .filt_o (data_f),
    .fall_o (data_fall_unused)
  );

  assign in_xfer = (state_q == SEND) || (state_q == ACK) ||
                   (state_q == WAIT_REL);
  // wd_q counts cycles since clock release, starting at 1
  assign wd_hit  = in_xfer && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  assign tx_ready           = (state_q == IDLE);
  assign tx_busy            = ~tx_ready;
  assign tx_done            = done_q;
  assign tx_err             = err_q;
  assign ps2_clk_drive_low  = clk_dl_q;
  assign ps2_data_drive_low = data_dl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      inh_q     <= '0;
      wd_q      <= '0;
      clk_dl_q  <= 1'b0;
      data_dl_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (in_xfer) wd_q <= wd_q + 1'b1;
      if (wd_hit) begin
        clk_dl_q  <= 1'b0;
        data_dl_q <= 1'b0;
        err_q     <= 1'b1;
        state_q   <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            clk_dl_q  <= 1'b0;
            data_dl_q <= 1'b0;
            bit_q     <= '0;
            inh_q     <= '0;
            wd_q      <= '0;
            if (tx_start) begin
              shift_q  <= ps2_frame(tx_data);
              clk_dl_q <= 1'b1;
              state_q  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
              data_dl_q <= 1'b1;
              state_q   <= REQ;
            end else begin
              inh_q <= inh_q + 1'b1;
            end
          end
          REQ: begin
            clk_dl_q <= 1'b0;
            bit_q    <= '0;
            wd_q     <= WW'(1);
            state_q  <= SEND;
          end
          SEND: begin
            if (clk_fall) begin
              data_dl_q <= ~shift_q[bit_q];
              bit_q     <= bit_q + 1'b1;
              if (bit_q == 4'(FRAME_BITS - 1)) state_q <= ACK;
            end
          end
          ACK: begin
            if (clk_fall) begin
              if (!data_f) begin
                state_q <= WAIT_REL;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          WAIT_REL: begin
            if (clk_f && data_f) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Device clocks after seeing clk released with data low, samples on rising edges.
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TMO  = 400;
  localparam int FL   = 2;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       clk_dl, data_dl;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int nrdy_cnt = 0;

  assign ps2_clk_line  = dev_clk & ~clk_dl;
  assign ps2_data_line = dev_data & ~data_dl;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_data            (tx_data),
    .tx_start           (tx_start),
    .tx_ready           (tx_ready),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_err             (tx_err),
    .ps2_clk_in         (ps2_clk_line),
    .ps2_data_in        (ps2_data_line),
    .ps2_clk_drive_low  (clk_dl),
    .ps2_data_drive_low (data_dl)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if ((tx_done || tx_err) && !tx_ready) nrdy_cnt++;
  endtask

  task automatic start_tx(input logic [7:0] d);
    tick();
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic settle();
    int w;
    w = 0;
    while (done_cnt + err_cnt == 0 && w < 80) begin
      tick();
      w++;
    end
    repeat (4) tick();
  endtask

  task automatic dev_xfer(input int nfalls, input bit ack,
                          output logic [9:0] got);
    int w;
    got = '0;
    w = 0;
    while (!(clk_dl === 1'b0 && data_dl === 1'b1) && w < 200) begin
      tick();
      w++;
    end
    n_cmp++;
    if (w >= 200) begin
      n_bad++;
      $display("FAIL dev_start: waited %0d cycles, required release", w);
      return;
    end
    for (int i = 0; i < nfalls; i++) begin
      repeat (HALF / 2) tick();
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (HALF - HALF / 2) tick();
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (i < 10) got[i] = ps2_data_line;
      dev_clk = 1'b1;
    end
    repeat (5) tick();
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({tx_ready, tx_busy, tx_done, tx_err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_status: got %b want 1000",
               {tx_ready, tx_busy, tx_done, tx_err});
    end
    n_cmp++;
    if ({clk_dl, data_dl} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_drives: got %b want 00", {clk_dl, data_dl});
    end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (tx_ready !== 1'b1 || clk_dl !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: ready %b cdl %b want 1 0",
               tx_ready, clk_dl);
    end
  endtask

  task automatic test_set_led();
    logic [9:0] got;
    int n;
    done_cnt = 0;
    err_cnt  = 0;
    start_tx(8'hED);
    n = 0;
    while (clk_dl === 1'b1 && data_dl === 1'b0 && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != INH) begin
      n_bad++;
      $display("FAIL inhibit_len: got %0d want %0d", n, INH);
    end
    n_cmp++;
    if ({clk_dl, data_dl} !== 2'b11) begin
      n_bad++;
      $display("FAIL req_both_low: got %b want 11", {clk_dl, data_dl});
    end
    tick();
    n_cmp++;
    if ({clk_dl, data_dl} !== 2'b01) begin
      n_bad++;
      $display("FAIL send_entry: got %b want 01", {clk_dl, data_dl});
    end
    dev_xfer(11, 1'b1, got);
    settle();
    n_cmp++;
    if (got !== 10'b11_1110_1101) begin
      n_bad++;
      $display("FAIL led_frame: got %b want 1111101101", got);
    end
    n_cmp++;
    if (done_cnt != 1 || err_cnt != 0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL led_done: done %0d err %0d rdy %b want 1 0 1",
               done_cnt, err_cnt, tx_ready);
    end
  endtask

  task automatic test_frames();
    logic [7:0] tbl[$];
    logic       par_tbl[$];
    logic [9:0] got, exp;
    tbl     = '{8'h01, 8'hFF};
    par_tbl = '{1'b0, 1'b1};
    for (int i = 0; i < 5; i++) tbl.push_back(8'($urandom));
    foreach (tbl[k]) begin
      exp      = model_frame(tbl[k]);
      done_cnt = 0;
      err_cnt  = 0;
      start_tx(tbl[k]);
      dev_xfer(11, 1'b1, got);
      settle();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL frame[%0d] %h: got %b want %b", k, tbl[k], got, exp);
      end
      if (k < 2) begin
        n_cmp++;
        if (got[8] !== par_tbl[k]) begin
          n_bad++;
          $display("FAIL parity %h: got %b want %b",
                   tbl[k], got[8], par_tbl[k]);
        end
      end
      n_cmp++;
      if (done_cnt != 1 || err_cnt != 0) begin
        n_bad++;
        $display("FAIL frame_done[%0d]: done %0d err %0d want 1 0",
                 k, done_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int w, n;
    done_cnt = 0;
    err_cnt  = 0;
    start_tx(8'($urandom));
    w = 0;
    while (!(clk_dl === 1'b1 && data_dl === 1'b1) && w < 40) begin
      tick();
      w++;
    end
    n = 0;
    while (tx_err !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != TMO) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d want %0d", n, TMO);
    end
    n_cmp++;
    if ({clk_dl, data_dl} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_release: got %b want 00", {clk_dl, data_dl});
    end
    repeat (10) tick();
    n_cmp++;
    if (done_cnt != 0 || err_cnt != 1 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_pulses: done %0d err %0d rdy %b want 0 1 1",
               done_cnt, err_cnt, tx_ready);
    end
  endtask

  task automatic test_nack();
    logic [9:0] got;
    logic [7:0] d;
    d        = 8'($urandom);
    done_cnt = 0;
    err_cnt  = 0;
    start_tx(d);
    dev_xfer(11, 1'b0, got);
    repeat (10) tick();
    n_cmp++;
    if (got !== model_frame(d)) begin
      n_bad++;
      $display("FAIL nack_frame: got %b want %b", got, model_frame(d));
    end
    n_cmp++;
    if (done_cnt != 0 || err_cnt != 1 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL nack_err: done %0d err %0d rdy %b want 0 1 1",
               done_cnt, err_cnt, tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    logic [7:0] d;
    logic       busy_seen;
    d         = 8'($urandom);
    busy_seen = 1'b0;
    done_cnt  = 0;
    err_cnt   = 0;
    start_tx(d);
    fork
      dev_xfer(11, 1'b1, got);
      begin
        repeat (150) @(negedge clk);
        busy_seen = tx_busy;
        tx_data   = ~d;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
      end
    join
    settle();
    repeat (20) tick();
    n_cmp++;
    if (busy_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy: got %b want 1", busy_seen);
    end
    n_cmp++;
    if (got !== model_frame(d)) begin
      n_bad++;
      $display("FAIL b2b_frame: got %b want %b", got, model_frame(d));
    end
    n_cmp++;
    if (done_cnt != 1 || clk_dl !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ignored: done %0d cdl %b rdy %b want 1 0 1",
               done_cnt, clk_dl, tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    logic [7:0] d;
    d = 8'($urandom);
    start_tx(d);
    dev_xfer(4, 1'b1, got);
    n_cmp++;
    if (got[3:0] !== d[3:0]) begin
      n_bad++;
      $display("FAIL partial_bits: got %b want %b", got[3:0], d[3:0]);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({clk_dl, data_dl, tx_ready, tx_busy} !== 4'b0010) begin
      n_bad++;
      $display("FAIL async_reset: got %b want 0010",
               {clk_dl, data_dl, tx_ready, tx_busy});
    end
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    repeat (3) tick();
    start_tx(8'hFF);
    dev_xfer(11, 1'b1, got);
    settle();
    n_cmp++;
    if (got !== 10'b11_1111_1111) begin
      n_bad++;
      $display("FAIL after_reset_frame: got %b want 1111111111", got);
    end
    n_cmp++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_bad++;
      $display("FAIL after_reset_done: done %0d err %0d want 1 0",
               done_cnt, err_cnt);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++;
      $display("FAIL done_err_overlap: got %0d want 0", both_cnt);
    end
    n_cmp++;
    if (nrdy_cnt != 0) begin
      n_bad++;
      $display("FAIL ready_at_pulse: got %0d late cycles want 0", nrdy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_set_led();
    test_frames();
    test_timeout();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
